// File: rtl/morse_sequencer.sv
// Plays one stored Morse character on a single LED, optionally repeated with off-gaps
// between copies. Unit timing comes from a free-running prescaler realigned on every start.
module morse_sequencer #(
    parameter int TICK_DIV  = 25000000,
    parameter int GAP_UNITS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] sel,
    input  logic [1:0] repeats,
    output logic       led,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int GW = (GAP_UNITS < 2) ? 1 : $clog2(GAP_UNITS + 1);
    localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_UNITS);

    // Handshake: start is a request honoured only in IDLE with abort low; busy rises the
    // following cycle and done pulses once when the final unit completes without abort.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [13:0] pattern_of(input logic [2:0] s);
        case (s)
            3'd0:    pattern_of = 14'b10111_000000000;
            3'd1:    pattern_of = 14'b111010101_00000;
            3'd2:    pattern_of = 14'b11101011101_000;
            3'd3:    pattern_of = 14'b1110101_0000000;
            3'd4:    pattern_of = 14'b1_0000000000000;
            3'd5:    pattern_of = 14'b101011101_00000;
            3'd6:    pattern_of = 14'b111011101_00000;
            default: pattern_of = 14'b1010101_0000000;
        endcase
    endfunction

    function automatic logic [3:0] length_of(input logic [2:0] s);
        case (s)
            3'd0:    length_of = 4'd5;
            3'd1:    length_of = 4'd9;
            3'd2:    length_of = 4'd11;
            3'd3:    length_of = 4'd7;
            3'd4:    length_of = 4'd1;
            3'd5:    length_of = 4'd9;
            3'd6:    length_of = 4'd9;
            default: length_of = 4'd7;
        endcase
    endfunction

    state_t          state_q, state_n;
    logic [13:0]     shift_q, shift_n;
    logic [3:0]      rem_q, rem_n;
    logic [1:0]      reps_q, reps_n;
    logic [GW-1:0]   gap_q, gap_n;
    logic [2:0]      sel_q, sel_n;
    logic [PW-1:0]   presc_q, presc_n;
    logic            led_n, busy_n, done_n;
    logic            tick;

    assign tick      = (presc_q == '0);
    assign state_dbg = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            rem_q   <= '0;
            reps_q  <= '0;
            gap_q   <= '0;
            sel_q   <= '0;
            presc_q <= PRESC_LOAD;
            led     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            rem_q   <= rem_n;
            reps_q  <= reps_n;
            gap_q   <= gap_n;
            sel_q   <= sel_n;
            presc_q <= presc_n;
            led     <= led_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        rem_n   = rem_q;
        reps_n  = reps_q;
        gap_n   = gap_q;
        sel_n   = sel_q;
        presc_n = tick ? PRESC_LOAD : presc_q - 1'b1;

        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_n   = sel;
                        reps_n  = repeats;
                        shift_n = pattern_of(sel);
                        rem_n   = length_of(sel);
                        presc_n = PRESC_LOAD;
                        state_n = S_SEND;
                    end
                end
                S_SEND: begin
                    if (tick) begin
                        if (rem_q > 4'd1) begin
                            shift_n = {shift_q[12:0], 1'b0};
                            rem_n   = rem_q - 4'd1;
                        end else if (reps_q != 2'd0) begin
                            gap_n   = GAP_LOAD;
                            state_n = S_GAP;
                        end else begin
                            state_n = S_DONE;
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (gap_q == GW'(1)) begin
                            shift_n = pattern_of(sel_q);
                            rem_n   = length_of(sel_q);
                            reps_n  = reps_q - 2'd1;
                            presc_n = PRESC_LOAD;
                            state_n = S_SEND;
                        end else begin
                            gap_n = gap_q - GW'(1);
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        led_n  = (state_n == S_SEND) && shift_n[13];
        busy_n = (state_n == S_SEND) || (state_n == S_GAP);
        done_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed and randomized checks of morse_sequencer against a per-cycle waveform model
// built from the character strings, repeat count and gap length.
module tb_morse_sequencer;

    localparam int TD  = 4;
    localparam int GAP = 3;

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic [2:0] sel;
    logic [1:0] repeats;
    logic       led;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    // Each entry is the expected {led, busy, done} for one cycle.
    logic [2:0] exp_q[$];

    string pats[8] = '{"10111", "111010101", "11101011101", "1110101",
                       "1", "101011101", "111011101", "1010101"};

    morse_sequencer #(.TICK_DIV(TD), .GAP_UNITS(GAP)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .sel      (sel),
        .repeats  (repeats),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed {led,busy,done}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic build_expected(input int s, input int r);
        exp_q.delete();
        for (int rep = 0; rep <= r; rep++) begin
            for (int j = 0; j < pats[s].len(); j++) begin
                for (int t = 0; t < TD; t++)
                    exp_q.push_back({(pats[s][j] == "1") ? 1'b1 : 1'b0, 1'b1, 1'b0});
            end
            if (rep < r) begin
                for (int t = 0; t < GAP * TD; t++) exp_q.push_back(3'b010);
            end
        end
        exp_q.push_back(3'b001);
        for (int t = 0; t < 4; t++) exp_q.push_back(3'b000);
    endtask

    // Called at a negedge; k counts cycles after the start was accepted (first = 1).
    task automatic play(input int s, input int r, input int abort_k, input int change_k,
                        input int reset_k, input bit start_in_done);
        int k;
        logic [2:0] e;
        build_expected(s, r);
        sel = 3'(s);
        repeats = 2'(r);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            k++;
            e = exp_q.pop_front();
            check($sformatf("seq s%0d r%0d k%0d", s, r, k), {led, busy, done}, e);
            if (k == abort_k) begin
                abort = 1'b1;
                @(posedge clock);
                #1 abort = 1'b0;
                exp_q.delete();
                for (int t = 0; t < 4; t++) begin
                    @(negedge clock);
                    check($sformatf("after_abort s%0d k%0d t%0d", s, k, t), {led, busy, done}, 3'b000);
                end
                return;
            end
            if (k == reset_k) begin
                #2 reset = 1'b0;
                #1 check($sformatf("async_reset s%0d k%0d", s, k), {led, busy, done}, 3'b000);
                @(negedge clock);
                check("reset_held", {led, busy, done}, 3'b000);
                reset = 1'b1;
                exp_q.delete();
                return;
            end
            if (k == change_k) begin
                sel = 3'(s) ^ 3'(1 + $urandom_range(0, 6));
                repeats = 2'($urandom_range(0, 3));
                start = 1'b1;
                @(posedge clock);
                #1 start = 1'b0;
            end else if (start_in_done && e == 3'b001) begin
                start = 1'b1;
                @(posedge clock);
                #1 start = 1'b0;
            end
        end
    endtask

    initial begin
        int s;
        int r;
        int total;
        int ak;
        int ck;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        sel     = 3'd0;
        repeats = 2'd0;

        #3 reset = 1'b0;
        #1 check("reset_async", {led, busy, done}, 3'b000);
        repeat (2) @(negedge clock);
        check("reset_held_idle", {led, busy, done}, 3'b000);
        reset = 1'b1;

        // E, single unit; start held during DONE must be ignored.
        play(4, 0, -1, -1, -1, 1'b1);
        // A once.
        play(0, 0, -1, -1, -1, 1'b0);
        // D twice with a gap.
        play(3, 1, -1, -1, -1, 1'b0);
        // C with a start/sel change at unit 3.
        play(2, 0, -1, 13, -1, 1'b0);
        // G x3, aborted at unit 5, then a fresh start.
        play(6, 2, 21, -1, -1, 1'b0);
        play(1, 0, -1, -1, -1, 1'b0);

        // abort and start together in IDLE: nothing starts.
        sel = 3'd4;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock);
        #1 begin
            start = 1'b0;
            abort = 1'b0;
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            check($sformatf("abort_start_idle t%0d", t), {led, busy, done}, 3'b000);
        end

        // Reset mid-gap, then E behaves as from power-up.
        play(3, 1, -1, -1, 32, 1'b0);
        play(4, 0, -1, -1, -1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            s = $urandom_range(0, 7);
            r = $urandom_range(0, 3);
            total = TD * (pats[s].len() * (r + 1) + GAP * r);
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, total) : -1;
            ck = ($urandom_range(0, 1) == 0) ? $urandom_range(1, total) : -1;
            play(s, r, ak, ck, -1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
